// File: rtl/issue_queue_n.sv
`default_nettype none
// ============================================================================
//  Module   : issue_queue_n
//  Purpose  : In-order decode-to-issue instruction queue. Accepts up to IN_W
//             sparse lanes per cycle (compacted in lane order) and presents
//             the oldest OUT_W entries. Issue pops any prefix via pop_cnt.
//  Revision : 1.0 - initial release
// ============================================================================
module issue_queue_n #(
    parameter int ENTRY_W = 32,
    parameter int DEPTH   = 8,
    parameter int IN_W    = 2,
    parameter int OUT_W   = 2
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           flush,
    input  logic                           hold,
    input  logic [IN_W-1:0]                in_valid,
    input  logic [IN_W*ENTRY_W-1:0]        in_data,
    output logic                           in_ready,
    output logic [OUT_W*ENTRY_W-1:0]       out_data,
    output logic [$clog2(OUT_W+1)-1:0]     out_cnt,
    input  logic [$clog2(OUT_W+1)-1:0]     pop_cnt,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           empty,
    output logic                           full
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_OC_W  = $clog2(OUT_W + 1);
    // Sums of a pointer and an offset need one extra bit before wrapping.
    localparam int c_SUM_W = c_CNT_W + 1;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic [c_SUM_W-1:0] w_off [IN_W];
    logic [c_CNT_W-1:0] w_nvalid;
    logic [c_CNT_W-1:0] w_npush;
    logic [c_OC_W-1:0]  w_out_cnt;
    logic [c_OC_W-1:0]  w_pop;
    logic               w_push;

    // Pointer wrap modulo DEPTH (DEPTH is a power of two, so this is a mask).
    function automatic logic [c_PTR_W-1:0] f_wrap(input logic [c_SUM_W-1:0] v);
        return c_PTR_W'(v % c_SUM_W'(DEPTH));
    endfunction

    // Compaction: each valid lane lands at tail + (number of valid older lanes).
    always_comb begin
        w_nvalid = '0;
        for (int i = 0; i < IN_W; i++) begin
            w_off[i] = c_SUM_W'(w_nvalid);
            w_nvalid = w_nvalid + c_CNT_W'(in_valid[i]);
        end
    end

    // Handshake and effective pop; readiness looks only at registered count.
    always_comb begin
        in_ready  = (r_count <= c_CNT_W'(DEPTH - IN_W));
        w_push    = in_ready && (|in_valid);
        w_npush   = w_push ? w_nvalid : '0;
        w_out_cnt = (r_count < c_CNT_W'(OUT_W)) ? c_OC_W'(r_count) : c_OC_W'(OUT_W);
        if (hold)
            w_pop = '0;
        else if (pop_cnt > w_out_cnt)
            w_pop = w_out_cnt;
        else
            w_pop = pop_cnt;
    end

    // Pointer and occupancy state; flush outranks any same-cycle push/pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= f_wrap(c_SUM_W'(r_head) + c_SUM_W'(w_pop));
            r_tail  <= f_wrap(c_SUM_W'(r_tail) + c_SUM_W'(w_npush));
            r_count <= r_count + w_npush - c_CNT_W'(w_pop);
        end
    end

    // Storage write; contents need no reset because reads are masked by out_cnt.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            for (int i = 0; i < IN_W; i++) begin
                if (in_valid[i])
                    r_mem[f_wrap(c_SUM_W'(r_tail) + w_off[i])] <= in_data[i*ENTRY_W +: ENTRY_W];
            end
        end
    end

    // Head window; lanes beyond out_cnt read as zero (the invalid marker).
    generate
        for (genvar j = 0; j < OUT_W; j++) begin : g_out
            logic [c_PTR_W-1:0] w_idx;
            assign w_idx = f_wrap(c_SUM_W'(r_head) + c_SUM_W'(j));
            assign out_data[j*ENTRY_W +: ENTRY_W] =
                (c_OC_W'(j) < w_out_cnt) ? r_mem[w_idx] : '0;
        end
    endgenerate

    assign out_cnt = w_out_cnt;
    assign count   = r_count;
    assign empty   = (r_count == '0);
    assign full    = !in_ready;

endmodule
`default_nettype wire

// File: tb/tb_issue_queue_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_issue_queue_n
//  Purpose  : Self-checking bench for issue_queue_n (DEPTH=8, IN_W=OUT_W=2)
//             against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_issue_queue_n;

    localparam int ENTRY_W = 32;
    localparam int DEPTH   = 8;
    localparam int IN_W    = 2;
    localparam int OUT_W   = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        hold;
    logic [1:0]  in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic [63:0] out_data;
    logic [1:0]  out_cnt;
    logic [1:0]  pop_cnt;
    logic [3:0]  count;
    logic        empty;
    logic        full;

    logic [31:0] q[$];
    int vectors     = 0;
    int miscompares = 0;

    issue_queue_n #(
        .ENTRY_W(ENTRY_W), .DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .hold(hold),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_data(out_data), .out_cnt(out_cnt), .pop_cnt(pop_cnt),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against what the reference queue implies.
    task automatic check_state(input string tag);
        int n;
        int oc;
        logic [63:0] od;
        n  = q.size();
        oc = (n < OUT_W) ? n : OUT_W;
        od = '0;
        for (int j = 0; j < oc; j++) od[j*32 +: 32] = q[j];
        chk({tag, ".count"},    64'(count),    64'(n));
        chk({tag, ".empty"},    64'(empty),    64'(n == 0));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'((DEPTH - n) >= IN_W));
        chk({tag, ".full"},     64'(full),     64'((DEPTH - n) < IN_W));
        chk({tag, ".out_cnt"},  64'(out_cnt),  64'(oc));
        chk({tag, ".out_data"}, out_data,      od);
    endtask

    // Reference behaviour for one clock edge, evaluated on pre-edge state.
    task automatic model_apply(input bit f, input bit h, input bit [1:0] v,
                               input logic [31:0] d0, input logic [31:0] d1, input int p);
        int n;
        int oc;
        int pe;
        bit rdy;
        n   = q.size();
        rdy = (DEPTH - n) >= IN_W;
        oc  = (n < OUT_W) ? n : OUT_W;
        pe  = h ? 0 : ((p < oc) ? p : oc);
        if (f) begin
            q.delete();
        end else begin
            repeat (pe) void'(q.pop_front());
            if (rdy) begin
                if (v[0]) q.push_back(d0);
                if (v[1]) q.push_back(d1);
            end
        end
    endtask

    task automatic step(input bit f, input bit h, input bit [1:0] v,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input int p, input string tag);
        flush    = f;
        hold     = h;
        in_valid = v;
        in_data  = {d1, d0};
        pop_cnt  = 2'(p);
        model_apply(f, h, v, d0, d1, p);
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic idle();
        flush = 1'b0; hold = 1'b0; in_valid = 2'b00; in_data = '0; pop_cnt = 2'd0;
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        #12;
        check_state("reset");
        chk("reset.out_data_zero", out_data, 64'd0);
        resetn = 1'b1;

        // Sparse push: only lane 1 valid, must land in slot 0.
        step(0, 0, 2'b10, 32'h0, 32'hA, 0, "sparse");
        chk("sparse.count", 64'(count), 64'd1);
        chk("sparse.lanes", out_data, {32'h0, 32'hA});

        // Fill two per cycle with no pops.
        step(1, 0, 2'b00, 0, 0, 0, "fill.flush");
        step(0, 0, 2'b11, 32'h11, 32'h12, 0, "fill1");
        step(0, 0, 2'b11, 32'h13, 32'h14, 0, "fill2");
        step(0, 0, 2'b11, 32'h15, 32'h16, 0, "fill3");
        chk("fill3.count", 64'(count), 64'd6);
        chk("fill3.in_ready", 64'(in_ready), 64'd1);
        step(0, 0, 2'b11, 32'h17, 32'h18, 0, "fill4");
        chk("fill4.count", 64'(count), 64'd8);
        chk("fill4.full", 64'(full), 64'd1);
        step(0, 0, 2'b11, 32'hFF, 32'hFF, 0, "fill5");
        chk("fill5.dropped", 64'(count), 64'd8);

        // Boundary: at count=7 in_ready is low even with a pop presented.
        step(0, 0, 2'b00, 0, 0, 1, "bnd.pop1");
        chk("bnd.count7_notready", 64'(in_ready), 64'd0);
        step(0, 0, 2'b11, 32'hEE, 32'hEE, 1, "bnd.push_dropped");
        chk("bnd.count6", 64'(count), 64'd6);

        // Stream 1..20 through, popping two per cycle, across the wrap.
        step(1, 0, 2'b00, 0, 0, 0, "wrap.flush");
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 2'b11, 32'(2*i+1), 32'(2*i+2), 2, "wrap");
            chk("wrap.order", out_data, {32'(2*i+2), 32'(2*i+1)});
            chk("wrap.cnt_le2", 64'(count <= 4'd2), 64'd1);
        end
        step(0, 0, 2'b00, 0, 0, 2, "wrap.drain");
        chk("wrap.empty", 64'(empty), 64'd1);
        step(0, 0, 2'b00, 0, 0, 2, "empty.pop_noop");

        // Flush beats same-cycle push and pop.
        step(0, 0, 2'b11, 32'h21, 32'h22, 0, "fp.a");
        step(0, 0, 2'b11, 32'h23, 32'h24, 0, "fp.b");
        step(0, 0, 2'b01, 32'h25, 32'h0, 0, "fp.c");
        chk("fp.count5", 64'(count), 64'd5);
        step(1, 0, 2'b11, 32'h26, 32'h27, 2, "fp.flush");
        chk("fp.count0", 64'(count), 64'd0);
        chk("fp.out_cnt0", 64'(out_cnt), 64'd0);

        // Hold ignores pop; oversized pop is clipped to out_cnt.
        step(0, 0, 2'b11, 32'h31, 32'h32, 0, "hc.a");
        step(0, 0, 2'b01, 32'h33, 32'h0, 0, "hc.b");
        step(0, 1, 2'b00, 0, 0, 2, "hc.hold");
        chk("hc.hold_count3", 64'(count), 64'd3);
        step(0, 0, 2'b00, 0, 0, 3, "hc.clip");
        chk("hc.clip_count1", 64'(count), 64'd1);
        chk("hc.clip_head", 64'(out_data[31:0]), 64'h33);

        // Asynchronous reset mid-cycle with count=5.
        step(0, 0, 2'b11, 32'h41, 32'h42, 0, "ar.a");
        step(0, 0, 2'b11, 32'h43, 32'h44, 0, "ar.b");
        chk("ar.count5", 64'(count), 64'd5);
        idle();
        #3;
        resetn = 1'b0;
        #1;
        q.delete();
        check_state("ar.async");
        #2;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check_state("ar.release");

        // Randomised traffic against the reference queue.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0),
                 2'($urandom_range(0, 3)), $urandom | 32'h1, $urandom | 32'h1,
                 int'($urandom_range(0, 3)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/issue_queue_n.md
# issue_queue_n

Parametrised in-order instruction queue between the decode stage and the issue stage of the superscalar core. It accepts up to IN_W decoded entries per cycle and presents the oldest OUT_W entries to issue. Issue reports how many it consumed, so any prefix can be popped. It generalises the fixed dual-in/dual-out queue to configurable lane counts and depth, and adds sparse-lane compaction, an issue-side hold and defined flush-versus-push priority.

## Interface
Parameters:
- ENTRY_W, 32: payload width of one entry (the decoded-instruction record).
- DEPTH, 8: number of entries. Must be a power of two, ≥ IN_W and ≥ OUT_W.
- IN_W, 2: write lanes, range 1..4.
- OUT_W, 2: read lanes, range 1..4.

Ports:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  discard all contents (mispredict or exception redirect).
- hold  in  1  issue-side stall; while high, pop_cnt is ignored.
- in_valid  in  IN_W  per-lane valid. Lane 0 is oldest. Any pattern is legal.
- in_data  in  IN_W*ENTRY_W  lane i occupies bits [i*ENTRY_W +: ENTRY_W].
- in_ready  out  1  high when free slots ≥ IN_W.
- out_data  out  OUT_W*ENTRY_W  head entries, lane 0 = oldest.
- out_cnt  out  $clog2(OUT_W+1)  valid out lanes, equal to min(count, OUT_W).
- pop_cnt  in  $clog2(OUT_W+1)  entries consumed this cycle.
- count  out  $clog2(DEPTH+1)  current occupancy.
- empty  out  1  count == 0.
- full  out  1  equal to !in_ready (the decode-side stall).

## Operation
- Storage is a circular buffer of DEPTH entries, with head pointer, tail pointer and count. Pointers wrap modulo DEPTH.
- Push:
  - Occurs when in_ready and |in_valid.
  - Valid lanes are compacted in lane order. With k set bits, they are written to tail, tail+1, …, tail+k−1, and tail advances by k.
  - Invalid lanes write nothing.
  - When in_ready=0, the input is dropped entirely. Upstream must hold it; there is no partial acceptance.
- Pop:
  - Effective pop is p = hold ? 0 : min(pop_cnt, out_cnt). Oversized pop_cnt is clipped, never underflows.
  - head advances by p.
- Count update: count_next = count + k − p. Push and pop in the same cycle are both applied.
- in_ready is computed from the registered count only, as DEPTH − count ≥ IN_W. Space freed by a same-cycle pop is not credited until the next cycle.
- out_data:
  - Lane j shows entry head+j (mod DEPTH) when j < out_cnt.
  - Lanes j ≥ out_cnt drive all-zeros, because a zero payload is the pipeline's invalid marker.
- No bypass: an entry pushed in cycle t is first visible on out_data in cycle t+1.
- Flush:
  - On the next edge, head=tail=count=0.
  - Flush has priority over push and pop in the same cycle, so those pushes are discarded and the pops are void.
- Reset: while resetn is low, head=tail=count=0 asynchronously. Storage contents are don't-care because out_data is masked by out_cnt.
- Reset output values: count=0, empty=1, in_ready=1, full=0, out_cnt=0, out_data=0.

## Timing
- Latency: push at edge t, visible at t+1. Pop at edge t, head moves at t+1.
- All outputs are combinational from registered state (head, count, storage). There are no input-to-output combinational paths.
- Throughput: sustained min(IN_W, OUT_W) entries per cycle, provided the DEPTH−count headroom holds.
- Boundaries:
  - At count = DEPTH−IN_W+1, in_ready drops even if a pop is presented that cycle.
  - With empty=1 and a pop request, the pop is a no-op.
  - A pointer wrap in the middle of a multi-lane push or pop must preserve order.
- Reset deassertion mid-stream: the queue starts empty, with no spurious out_cnt.

## Test plan
Settings: DEPTH=8, IN_W=2, OUT_W=2, ENTRY_W=32.

- **Reset:** pulse resetn low mid-cycle while count=5 → immediately count=0, empty=1, in_ready=1, out_cnt=0, out_data=0.
- **Sparse push:** in_valid=2'b10, lane1=0xA on an empty queue → next cycle count=1, out_cnt=1, out lane0=0xA, lane1=0.
- **Fill:** push 2 per cycle with pop_cnt=0.
  - After 3 cycles: count=6, in_ready=1.
  - After 4 cycles: count=8, full=1.
  - A fifth push of 0xFF is dropped; count stays 8.
- **Wrap/order:** push 1..20 two per cycle while popping 2 per cycle for 10 cycles → outputs emerge exactly 1..20 in order across the pointer wrap, and count stays ≤2.
- **Flush priority:** count=5, flush=1 with in_valid=2'b11 and pop_cnt=2 in the same cycle → next cycle count=0, empty=1, out_cnt=0.
- **Hold and clip:**
  - count=3, hold=1, pop_cnt=2 → count stays 3.
  - Then hold=0, pop_cnt=3 (illegal) with out_cnt=2 → count becomes 1, and the head is the third entry pushed.
